// File: rtl/fetch_pc_controller_pkg.sv
// Shared definitions for the fetch PC controller: FSM state encoding and the
// HALT opcode, exported so the hazard and debug units decode identical values.
package fetch_pc_controller_pkg;

   localparam logic [1:0]  ST_RUN    = 2'd0;
   localparam logic [1:0]  ST_HOLD   = 2'd1;
   localparam logic [1:0]  ST_HALTED = 2'd2;

   localparam logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      RUN    = ST_RUN,
      HOLD   = ST_HOLD,
      HALTED = ST_HALTED
   } fetch_state_t;

endpackage

// File: rtl/fetch_pc_controller_adder.sv
// Generic unsigned adder, used for PC+1. The result wraps modulo 2^width.
module fetch_pc_controller_adder #(
   parameter int INPUT_OUTPUT_LENGTH = 11
) (
   input  logic [INPUT_OUTPUT_LENGTH-1:0] a,
   input  logic [INPUT_OUTPUT_LENGTH-1:0] b,
   output logic [INPUT_OUTPUT_LENGTH-1:0] sum
);

   // Carry-out is intentionally dropped so PC max + 1 wraps to zero.
   assign sum = a + b;

endmodule

// File: rtl/fetch_pc_controller.sv
// Fetch-side program counter owner. Consumes the ID branch decision, drives the
// program-memory address, flushes IF/ID on redirect, honours hazard stalls and
// debug-unit enable, and freezes fetch when HALT is fetched.
// Optional build macro: BRANCH_DELAY_SLOT_EN (ties o_flush to 0 for MIPS-style
// delay-slot semantics; redirect timing is unchanged).
module fetch_pc_controller
   import fetch_pc_controller_pkg::*;
#(
   parameter int CANT_BITS_ADDR        = 11,
   parameter int CANT_BITS_INSTRUCTION = 32,
   parameter logic [CANT_BITS_INSTRUCTION-1:0] HALT_OPCODE_P = CANT_BITS_INSTRUCTION'(HALT_OPCODE),
   parameter int CANT_BITS_CONTADOR    = 32
) (
   input  logic                             i_clock,
   input  logic                             i_reset,
   input  logic                             i_enable,
   input  logic                             i_stall,
   input  logic                             i_branch_control,
   input  logic [CANT_BITS_ADDR-1:0]        i_branch_dir,
   input  logic [CANT_BITS_INSTRUCTION-1:0] i_instruction,
   output logic [CANT_BITS_ADDR-1:0]        o_pc,
   output logic [CANT_BITS_ADDR-1:0]        o_adder_pc,
   output logic                             o_flush,
   output logic                             o_halt,
   output logic [CANT_BITS_CONTADOR-1:0]    o_cycle_count
);

   fetch_state_t                state;
   fetch_state_t                state_next;
   logic [CANT_BITS_ADDR-1:0]   pc;
   logic [CANT_BITS_ADDR-1:0]   pc_next;
   logic [CANT_BITS_ADDR-1:0]   pc_plus_one;
   logic [CANT_BITS_ADDR-1:0]   pending;
   logic [CANT_BITS_ADDR-1:0]   pending_next;
   logic                        halt;
   logic                        halt_next;
   logic                        redirect;
   logic [CANT_BITS_CONTADOR-1:0] cycle_count;

   fetch_pc_controller_adder #(
      .INPUT_OUTPUT_LENGTH(CANT_BITS_ADDR)
   ) u_adder_pc (
      .a  (pc),
      .b  (CANT_BITS_ADDR'(1)),
      .sum(pc_plus_one)
   );

   // Next-PC selection and redirect detection, in branch > stall > HALT > +1 priority.
   always_comb begin
      state_next   = state;
      pc_next      = pc;
      pending_next = pending;
      halt_next    = halt;
      redirect     = 1'b0;
      case (state)
         RUN: begin
            if (i_branch_control && !i_stall) begin
               pc_next  = i_branch_dir;
               redirect = 1'b1;
            end else if (i_branch_control && i_stall) begin
               // Target is parked until the stall releases.
               pending_next = i_branch_dir;
               state_next   = HOLD;
            end else if (i_stall) begin
               pc_next = pc;
            end else if (i_instruction == HALT_OPCODE_P) begin
               halt_next  = 1'b1;
               state_next = HALTED;
            end else begin
               pc_next = pc_plus_one;
            end
         end
         HOLD: begin
            // First latched target wins; new branch requests are ignored here.
            if (!i_stall) begin
               pc_next    = pending;
               redirect   = 1'b1;
               state_next = RUN;
            end
         end
         default: begin
            // HALTED: everything frozen until reset.
         end
      endcase
   end

   // State, PC, pending target, halt flag and cycle counter; frozen when not enabled.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state       <= RUN;
         pc          <= '0;
         pending     <= '0;
         halt        <= 1'b0;
         cycle_count <= '0;
      end else if (i_enable) begin
         state   <= state_next;
         pc      <= pc_next;
         pending <= pending_next;
         halt    <= halt_next;
         if (state != HALTED) begin
            cycle_count <= cycle_count + CANT_BITS_CONTADOR'(1);
         end
      end
   end

   assign o_pc          = pc;
   assign o_adder_pc    = pc_plus_one;
   assign o_halt        = halt;
   assign o_cycle_count = cycle_count;

`ifdef BRANCH_DELAY_SLOT_EN
   // Delay-slot instruction after a branch must complete, so IF/ID is never cleared.
   assign o_flush = 1'b0;
   logic unused_flush_terms;
   assign unused_flush_terms = redirect;
`else
   // Mealy flush so IF/ID clears on the same edge that the PC is redirected.
   assign o_flush = i_reset & i_enable & redirect;
`endif

endmodule

// File: tb/tb_fetch_pc_controller.sv
// Self-checking bench for fetch_pc_controller: directed scenarios plus a
// randomized run, all compared against a rule-level reference model.
`timescale 1ns/1ps
module tb_fetch_pc_controller;

   localparam int AW = 11;
   localparam int IW = 32;
   localparam int CW = 32;
   localparam logic [IW-1:0] HALT = 32'hFFFF_FFFF;
   localparam logic [IW-1:0] NOP  = 32'h0000_0000;

   logic          i_clock = 1'b0;
   logic          i_reset = 1'b0;
   logic          i_enable = 1'b0;
   logic          i_stall = 1'b0;
   logic          i_branch_control = 1'b0;
   logic [AW-1:0] i_branch_dir = '0;
   logic [IW-1:0] i_instruction = '0;
   logic [AW-1:0] o_pc;
   logic [AW-1:0] o_adder_pc;
   logic          o_flush;
   logic          o_halt;
   logic [CW-1:0] o_cycle_count;

   int checks = 0;
   int errors = 0;

   // Reference model: what the fetch stage should look like after each edge.
   int          m_pc;
   bit          m_waiting;     // a redirect is parked behind a stall
   int          m_target;
   bit          m_halted;
   logic [CW-1:0] m_count;
   bit          exp_flush;
   logic        obs_flush;

   fetch_pc_controller u_dut (
      .i_clock         (i_clock),
      .i_reset         (i_reset),
      .i_enable        (i_enable),
      .i_stall         (i_stall),
      .i_branch_control(i_branch_control),
      .i_branch_dir    (i_branch_dir),
      .i_instruction   (i_instruction),
      .o_pc            (o_pc),
      .o_adder_pc      (o_adder_pc),
      .o_flush         (o_flush),
      .o_halt          (o_halt),
      .o_cycle_count   (o_cycle_count)
   );

   always #5 i_clock = ~i_clock;

   task automatic model_reset();
      m_pc = 0; m_waiting = 0; m_target = 0; m_halted = 0; m_count = '0;
   endtask

   // Apply one cycle of inputs, sample o_flush before the edge, advance the model.
   task automatic tick(input bit en, input bit st, input bit br,
                       input int dir, input logic [IW-1:0] instr);
      i_enable = en; i_stall = st; i_branch_control = br;
      i_branch_dir = AW'(dir); i_instruction = instr;
      #2;
      obs_flush = o_flush;
      exp_flush = 0;
      if (en && !m_halted) begin
         m_count = m_count + 1;
         if (m_waiting) begin
            if (!st) begin m_pc = m_target; m_waiting = 0; exp_flush = 1; end
         end else if (br && !st) begin
            m_pc = dir; exp_flush = 1;
         end else if (br) begin
            m_target = dir; m_waiting = 1;
         end else if (!st) begin
            if (instr == HALT) m_halted = 1;
            else m_pc = (m_pc + 1) % (1 << AW);
         end
      end
`ifdef BRANCH_DELAY_SLOT_EN
      exp_flush = 0;
`endif
      @(posedge i_clock);
      #1;
   endtask

   task automatic nop_tick();
      tick(1, 0, 0, 0, NOP);
   endtask

   task automatic do_reset();
      @(negedge i_clock);
      i_reset = 0;
      model_reset();
      @(negedge i_clock);
      i_reset = 1;
      i_enable = 0; i_stall = 0; i_branch_control = 0;
   endtask

   task automatic test_reset();
      @(negedge i_clock);
      i_reset = 0;
      i_enable = 1; i_branch_control = 1; i_stall = 0; i_branch_dir = 11'd55;
      #1;
      checks++;
      if (o_flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %0b expected 0", o_flush); end
      @(posedge i_clock); #1;
      checks++;
      if (o_pc !== 0 || o_adder_pc !== 1 || o_halt !== 0 || o_cycle_count !== 0) begin
         errors++;
         $display("FAIL reset_state got pc=%0d adder=%0d halt=%0b cnt=%0d expected 0 1 0 0",
                  o_pc, o_adder_pc, o_halt, o_cycle_count);
      end
      model_reset();
      @(negedge i_clock);
      i_reset = 1; i_enable = 0; i_branch_control = 0;
      $display("reset: pc=%0d adder=%0d halt=%0b cnt=%0d", o_pc, o_adder_pc, o_halt, o_cycle_count);
   endtask

   task automatic test_sequential();
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         nop_tick();
         checks++;
         if (o_pc !== AW'(k) || o_adder_pc !== AW'(k + 1) || obs_flush !== 1'b0) begin
            errors++;
            $display("FAIL seq_pc got pc=%0d adder=%0d flush=%0b expected %0d %0d 0",
                     o_pc, o_adder_pc, obs_flush, k, k + 1);
         end
         $display("seq: pc=%0d adder=%0d", o_pc, o_adder_pc);
      end
      checks++;
      if (o_cycle_count !== 5) begin errors++; $display("FAIL seq_count got %0d expected 5", o_cycle_count); end
   endtask

   task automatic test_branch();
      do_reset();
      repeat (3) nop_tick();
      tick(1, 0, 1, 40, NOP);
      checks++;
      if (obs_flush !== exp_flush || o_pc !== 40) begin
         errors++;
         $display("FAIL branch got flush=%0b pc=%0d expected %0b 40", obs_flush, o_pc, exp_flush);
      end
      $display("branch: flush=%0b pc=%0d", obs_flush, o_pc);
      nop_tick();
      checks++;
      if (obs_flush !== 1'b0 || o_pc !== 41) begin
         errors++;
         $display("FAIL branch_after got flush=%0b pc=%0d expected 0 41", obs_flush, o_pc);
      end
   endtask

   task automatic test_stall_branch();
      do_reset();
      repeat (7) nop_tick();
      tick(1, 1, 1, 100, NOP);          // branch parked behind stall
      tick(1, 1, 1, 77, NOP);           // later target must not replace it
      tick(1, 1, 0, 0, HALT);           // HALT seen while holding is ignored
      checks++;
      if (o_pc !== 7 || obs_flush !== 1'b0 || o_halt !== 1'b0) begin
         errors++;
         $display("FAIL stall_hold got pc=%0d flush=%0b halt=%0b expected 7 0 0", o_pc, obs_flush, o_halt);
      end
      tick(1, 0, 1, 55, NOP);           // release; branch request ignored
      checks++;
      if (o_pc !== 100 || obs_flush !== exp_flush) begin
         errors++;
         $display("FAIL stall_release got pc=%0d flush=%0b expected 100 %0b", o_pc, obs_flush, exp_flush);
      end
      $display("stall_release: pc=%0d flush=%0b", o_pc, obs_flush);
      nop_tick();
      checks++;
      if (o_pc !== 101 || obs_flush !== 1'b0 || o_cycle_count !== 12) begin
         errors++;
         $display("FAIL stall_after got pc=%0d flush=%0b cnt=%0d expected 101 0 12", o_pc, obs_flush, o_cycle_count);
      end
   endtask

   task automatic test_halt();
      do_reset();
      repeat (9) nop_tick();
      tick(1, 0, 0, 0, HALT);
      checks++;
      if (o_halt !== 1'b1 || o_pc !== 9 || o_cycle_count !== 10) begin
         errors++;
         $display("FAIL halt_enter got halt=%0b pc=%0d cnt=%0d expected 1 9 10", o_halt, o_pc, o_cycle_count);
      end
      for (int k = 0; k < 12; k++) begin
         tick(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2047), NOP);
         checks++;
         if (o_halt !== 1'b1 || o_pc !== 9 || o_cycle_count !== 10 || obs_flush !== 1'b0) begin
            errors++;
            $display("FAIL halt_frozen got halt=%0b pc=%0d cnt=%0d flush=%0b expected 1 9 10 0",
                     o_halt, o_pc, o_cycle_count, obs_flush);
         end
      end
      $display("halt: pc=%0d cnt=%0d", o_pc, o_cycle_count);
      @(negedge i_clock);
      i_reset = 0;
      #1;
      checks++;
      if (o_halt !== 0 || o_pc !== 0 || o_adder_pc !== 1 || o_cycle_count !== 0) begin
         errors++;
         $display("FAIL halt_reset got halt=%0b pc=%0d adder=%0d cnt=%0d expected 0 0 1 0",
                  o_halt, o_pc, o_adder_pc, o_cycle_count);
      end
      model_reset();
      @(negedge i_clock);
      i_reset = 1;
   endtask

   task automatic test_wrap();
      do_reset();
      tick(1, 0, 1, 2047, NOP);
      checks++;
      if (o_pc !== 2047 || o_adder_pc !== 0) begin
         errors++;
         $display("FAIL wrap_top got pc=%0d adder=%0d expected 2047 0", o_pc, o_adder_pc);
      end
      nop_tick();
      checks++;
      if (o_pc !== 0 || o_adder_pc !== 1) begin
         errors++;
         $display("FAIL wrap_zero got pc=%0d adder=%0d expected 0 1", o_pc, o_adder_pc);
      end
      $display("wrap: pc=%0d adder=%0d", o_pc, o_adder_pc);
   endtask

   task automatic test_enable_toggle();
      int seq_cont[$];
      do_reset();
      // Continuous reference sequence from the model's rules.
      for (int k = 1; k <= 8; k++) seq_cont.push_back(k);
      for (int k = 0; k < 8; k++) begin
         tick(1, 0, 0, 0, NOP);
         checks++;
         if (o_pc !== AW'(seq_cont[k])) begin
            errors++;
            $display("FAIL step_pc got %0d expected %0d", o_pc, seq_cont[k]);
         end
         tick(0, 0, 1, 123, HALT);      // disabled edge: nothing may move
         checks++;
         if (o_pc !== AW'(seq_cont[k]) || obs_flush !== 1'b0 || o_halt !== 1'b0 || o_cycle_count !== CW'(k + 1)) begin
            errors++;
            $display("FAIL step_idle got pc=%0d flush=%0b halt=%0b cnt=%0d expected %0d 0 0 %0d",
                     o_pc, obs_flush, o_halt, o_cycle_count, seq_cont[k], k + 1);
         end
      end
      $display("step: pc=%0d cnt=%0d", o_pc, o_cycle_count);
   endtask

   task automatic test_branch_halt();
      do_reset();
      repeat (4) nop_tick();
      tick(1, 0, 1, 20, HALT);
      checks++;
      if (o_halt !== 1'b0 || o_pc !== 20 || obs_flush !== exp_flush) begin
         errors++;
         $display("FAIL branch_halt got halt=%0b pc=%0d flush=%0b expected 0 20 %0b",
                  o_halt, o_pc, obs_flush, exp_flush);
      end
      $display("branch_halt: pc=%0d halt=%0b", o_pc, o_halt);
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 99) == 0) do_reset();
         tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 2047), ($urandom_range(0, 60) == 0) ? HALT : IW'($urandom_range(0, 1000)));
         checks++;
         if (o_pc !== AW'(m_pc) || o_adder_pc !== AW'(m_pc + 1) || o_halt !== m_halted ||
             o_cycle_count !== m_count || obs_flush !== exp_flush) begin
            errors++;
            $display("FAIL random got pc=%0d adder=%0d halt=%0b cnt=%0d flush=%0b expected %0d %0d %0b %0d %0b",
                     o_pc, o_adder_pc, o_halt, o_cycle_count, obs_flush,
                     m_pc, (m_pc + 1) % 2048, m_halted, m_count, exp_flush);
         end
         $display("rand %0d: pc=%0d halt=%0b cnt=%0d flush=%0b", k, o_pc, o_halt, o_cycle_count, obs_flush);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_sequential();
      test_branch();
      test_stall_branch();
      test_halt();
      test_wrap();
      test_enable_toggle();
      test_branch_halt();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_pc_controller.md
Name: fetch_pc_controller

Overview:
- Instruction-fetch end of the branch-resolution interface: consumes the ID-stage branch decision and target, and owns the program counter.
- Drives the program-memory address and the PC+1 value fed back to ID.
- Flushes IF/ID on redirect, honours hazard stalls and debug-unit stepping, and detects HALT to freeze fetch.
- Sits between the debug unit / hazard unit and program memory, ahead of the IF/ID register.

Parameters:
- CANT_BITS_ADDR, 11, PC and branch-target width (word addressing, PC steps by 1).
- CANT_BITS_INSTRUCTION, 32, fetched instruction width.
- HALT_OPCODE, 32'hFFFFFFFF, instruction encoding that stops fetch.
- CANT_BITS_CONTADOR, 32, cycle-counter width.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_enable  in  1  debug-unit enable (continuous run or single step); 0 freezes all state.
- i_stall  in  1  load-use stall from hazard unit; holds PC.
- i_branch_control  in  1  redirect request from ID.
- i_branch_dir  in  CANT_BITS_ADDR  redirect target from ID.
- i_instruction  in  CANT_BITS_INSTRUCTION  program-memory read data at o_pc (combinational read).
- o_pc  out  CANT_BITS_ADDR  program-memory address.
- o_adder_pc  out  CANT_BITS_ADDR  o_pc+1, passed to ID.
- o_flush  out  1  invalidate IF/ID on this edge.
- o_halt  out  1  sticky, fetch halted.
- o_cycle_count  out  CANT_BITS_CONTADOR  enabled, non-halted cycles since reset.

Behaviour:
- Reset (i_reset=0, async): o_pc=0, o_adder_pc=1, o_halt=0, o_cycle_count=0, pending target=0, state=RUN. o_flush forced 0 while reset is asserted.
- i_enable=0: no register updates, o_flush=0. A stepped run therefore behaves identically to a continuous run.
- States:
  - RUN: normal fetch.
  - HOLD: stalled with a latched pending redirect.
  - HALTED: fetch frozen.
- RUN, per enabled edge, in priority order:
  1. i_branch_control & !i_stall: o_pc<=i_branch_dir; o_flush=1 this cycle.
  2. i_branch_control & i_stall: latch i_branch_dir into pending; o_pc holds; o_flush=0; go to HOLD.
  3. i_stall: o_pc holds.
  4. i_instruction==HALT_OPCODE: o_pc holds; o_halt<=1; go to HALTED.
  5. Otherwise: o_pc<=o_pc+1.
- A branch and a HALT seen in the same cycle: the branch wins, because the HALT is on the wrong path and gets flushed.
- HOLD:
  - While i_stall=1: hold. Pending is not overwritten, so the first target wins.
  - When i_stall drops: o_pc<=pending; o_flush=1; go to RUN. i_branch_control is ignored on this release cycle.
- HALTED: PC, pending and counter frozen; o_flush=0; exit only by reset.
- o_flush is combinational (Mealy), so IF/ID clears on the same edge the PC updates.
- o_adder_pc = o_pc+1 modulo 2^CANT_BITS_ADDR; PC 2^CANT_BITS_ADDR-1 wraps to 0.
- o_cycle_count increments on every enabled edge while not HALTED, including stalled cycles, and wraps modulo its width.
- Reset asserted mid-HOLD or mid-HALTED returns immediately to the reset state; the pending target is discarded.

Optional Feature:
- Macro: BRANCH_DELAY_SLOT_EN.
- Defined: MIPS delay-slot semantics. o_flush is tied to 0, so the instruction after a branch completes; redirect timing is unchanged.
- Undefined: o_flush asserts on every redirect, as described above.

Decomposition:
- Shared package: state encoding localparams (RUN=2'd0, HOLD=2'd1, HALTED=2'd2) and HALT_OPCODE, so the hazard and debug units decode the same values.
- One sub-module: reuse the existing adder (INPUT_OUTPUT_LENGTH=CANT_BITS_ADDR) as u_adder_pc for PC+1.
- Everything else is a single always block plus a combinational next-PC/flush block.

Test Plan:
- Reset then 5 enabled cycles with NOPs -> o_pc 0,1,2,3,4,5; o_adder_pc=o_pc+1; o_cycle_count=5; o_flush=0.
- At o_pc=3, i_branch_control=1, i_branch_dir=11'd40 -> o_flush=1 that cycle; next o_pc=40 (flush stays 0 with BRANCH_DELAY_SLOT_EN).
- At o_pc=7, i_stall=1 for 3 cycles with branch to 100 asserted on the first stall cycle -> o_pc stays 7; release -> o_pc=100 with a one-cycle o_flush.
- i_instruction=32'hFFFFFFFF at o_pc=9 -> o_halt=1 sticky; o_pc=9 and counter frozen for 10+ cycles; assert i_reset=0 -> all outputs return to reset values.
- o_pc=2047 with no branch -> next o_pc=0, o_adder_pc=1; i_enable toggling 1/0 yields the same PC sequence as a continuous run.
- HALT fetched in the same cycle as i_branch_control=1 to 20 -> o_halt stays 0; o_pc=20.
